// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the generic FIFO controller.
//   MODE_DROP      : a write while full is discarded.
//   MODE_OVERWRITE : a write while full replaces the oldest word.
//   thresh_ok()    : parameter legality check used at elaboration.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned MODE_DROP      = 0;
    localparam int unsigned MODE_OVERWRITE = 1;

    // Almost-full must lie in 1..D, almost-empty in 0..D-1.
    function automatic bit thresh_ok(input int unsigned w,
                                     input int unsigned af,
                                     input int unsigned ae);
        int unsigned d;
        d = 32'd1 << w;
        return (af >= 1) && (af <= d) && (ae <= d - 1);
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// -----------------------------------------------------------------------------
// fifo_regfile
// 2**W x B storage array: synchronous write, asynchronous read.
// Ports:
//   i_clk     : clock
//   i_we      : write enable
//   i_w_addr  : write address
//   i_w_data  : write data
//   i_r_addr  : read address
//   o_r_data  : word at i_r_addr (combinational)
// -----------------------------------------------------------------------------
module fifo_regfile #(
    parameter int unsigned B = 8,
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_we,
    input  logic [W-1:0] i_w_addr,
    input  logic [B-1:0] i_w_data,
    input  logic [W-1:0] i_r_addr,
    output logic [B-1:0] o_r_data
);

    // Contents are intentionally not reset.
    logic [B-1:0] mem_q [2**W];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_w_addr] <= i_w_data;
        end
    end

    assign o_r_data = mem_q[i_r_addr];

endmodule

// File: rtl/fifo_ctrl_gen.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_gen
// Synchronous first-word-fall-through FIFO with selectable full-write policy,
// programmable almost-full/almost-empty thresholds, occupancy count, sticky
// overflow/underflow flags and synchronous flush.
// Ports:
//   i_clk          : clock, rising edge
//   i_reset        : asynchronous active-high reset
//   i_clr          : synchronous flush (pointers, count, sticky flags)
//   i_wr/i_wr_data : write request and data
//   i_rd           : read request, pops the word on o_rd_data
//   o_rd_data      : head word (from memory at rd_ptr)
//   o_empty/o_full : count == 0 / count == D
//   o_almost_full  : count >= AF_THRESH
//   o_almost_empty : count <= AE_THRESH
//   o_count        : occupancy 0..D
//   o_overflow     : sticky, write while full without an accepted read
//   o_underflow    : sticky, read while empty
// -----------------------------------------------------------------------------
module fifo_ctrl_gen
    import fifo_pkg::*;
#(
    parameter int unsigned B         = 8,
    parameter int unsigned W         = 4,
    parameter int unsigned MODE      = 0,
    parameter int unsigned AF_THRESH = 2**W - 2,
    parameter int unsigned AE_THRESH = 1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_wr,
    input  logic [B-1:0] i_wr_data,
    input  logic         i_rd,
    output logic [B-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_almost_full,
    output logic         o_almost_empty,
    output logic [W:0]   o_count,
    output logic         o_overflow,
    output logic         o_underflow
);

    localparam int unsigned D        = 2**W;
    localparam logic [W:0]  CNT_FULL = (W+1)'(D);
    localparam logic [W:0]  CNT_AF   = (W+1)'(AF_THRESH);
    localparam logic [W:0]  CNT_AE   = (W+1)'(AE_THRESH);
    localparam logic [W:0]  CNT_ONE  = (W+1)'(1);
    localparam logic [W-1:0] PTR_ONE = W'(1);

    if (!thresh_ok(W, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("fifo_ctrl_gen: AF_THRESH must be 1..D and AE_THRESH 0..D-1");
    end

    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         unf_q, unf_d;
    logic         mem_we;
    logic         is_empty;
    logic         is_full;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CNT_FULL);

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Next-state: flush wins over any read/write in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        mem_we   = 1'b0;

        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            case ({i_wr, i_rd})
                2'b01: begin
                    if (!is_empty) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        count_d  = count_q - CNT_ONE;
                    end else begin
                        unf_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (!is_full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        count_d  = count_q + CNT_ONE;
                    end else begin
                        ovf_d = 1'b1;
                        if (MODE == MODE_OVERWRITE) begin
                            // Oldest word is sacrificed; count stays at D.
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            rd_ptr_d = rd_ptr_q + PTR_ONE;
                        end
                    end
                end
                2'b11: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (!is_empty) begin
                        // Pass-through, legal even when full.
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end else begin
                        // Nothing to pop yet: keep the write, flag the read.
                        count_d = CNT_ONE;
                        unf_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: registered state only (read data via memory at rd_ptr).
    always_comb begin
        o_empty        = is_empty;
        o_full         = is_full;
        o_almost_full  = (count_q >= CNT_AF);
        o_almost_empty = (count_q <= CNT_AE);
        o_count        = count_q;
        o_overflow     = ovf_q;
        o_underflow    = unf_q;
    end

    fifo_regfile #(
        .B (B),
        .W (W)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_we     (mem_we),
        .i_w_addr (wr_ptr_q),
        .i_w_data (i_wr_data),
        .i_r_addr (rd_ptr_q),
        .o_r_data (o_rd_data)
    );

endmodule
